// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LSU memory port arbiter: FSM states, read-owner tags, byte-enable width.
package mem_arb_pkg;

  localparam int BE_W = 4;

  typedef enum logic {
    ARB  = 1'b0,
    FAIR = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    LS   = 2'd2
  } rd_owner_t;

  // Which requester owns the read data returning next cycle; stores and idle cycles own nothing.
  function automatic rd_owner_t owner_for(input logic fetch_gnt, input logic load_gnt);
    if (fetch_gnt) begin
      return IF;
    end
    if (load_gnt) begin
      return LS;
    end
    return NONE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port, BRAM port and stall outputs of mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  import mem_arb_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [BE_W-1:0]   ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall_if, stall_mem
  );

  // Pipeline requesters plus the BRAM.
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall_if, stall_mem
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts LSU grants that left a fetch waiting and flags when the next cycle must be a forced fetch slot.
module mem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic fair_trig
);

  localparam bit GUARD_EN = (STARVE_LIMIT != 0);
  localparam int CNT_W = GUARD_EN ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (clr) begin
      starve_cnt_next = '0;
    end else if (GUARD_EN && inc && (starve_cnt_reg != LIMIT_C)) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  // Trigger on the grant that brings the count up to the limit, so the forced slot follows immediately.
  assign fair_trig = GUARD_EN && inc && !clr && (starve_cnt_next == LIMIT_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter between instruction fetch and load/store: LSU priority with an IF starvation guard.
// Define MEM_ARB_PERF_EN to add saturating conflict and fetch-stall cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflict_cnt,
  output logic [31:0] perf_if_stall_cnt
`endif
);

  arb_state_t state_reg;
  arb_state_t state_next;
  rd_owner_t  rd_owner_reg;
  rd_owner_t  rd_owner_next;

  logic              if_gnt_c;
  logic              ls_gnt_c;
  logic              store_gnt;
  logic              load_gnt;
  logic              starve_inc;
  logic              starve_clr;
  logic              fair_trig;
  logic [BE_W-1:0]   mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              if_rvalid_c;
  logic              ls_rvalid_c;
  logic              stall_if_c;
  logic              stall_mem_c;

  genvar gi;

  // Grants are held low during reset so every output reads zero while rst is high.
  always_comb begin
    if_gnt_c = 1'b0;
    ls_gnt_c = 1'b0;
    if (!rst) begin
      if ((state_reg == FAIR) && bus.if_req) begin
        if_gnt_c = 1'b1;
      end else if (bus.ls_req) begin
        ls_gnt_c = 1'b1;
      end else if (bus.if_req) begin
        if_gnt_c = 1'b1;
      end
    end
  end

  assign store_gnt  = ls_gnt_c & bus.ls_we;
  assign load_gnt   = ls_gnt_c & ~bus.ls_we;
  assign starve_inc = (state_reg == ARB) & ls_gnt_c & bus.if_req;
  assign starve_clr = if_gnt_c | (state_reg == FAIR);

  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .fair_trig(fair_trig)
  );

  // FAIR lasts exactly one cycle whether or not IF actually used it.
  assign state_next    = ((state_reg == ARB) && fair_trig) ? FAIR : ARB;
  assign rd_owner_next = owner_for(if_gnt_c, load_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ARB;
      rd_owner_reg <= NONE;
    end else begin
      state_reg    <= state_next;
      rd_owner_reg <= rd_owner_next;
    end
  end

  for (gi = 0; gi < BE_W; gi++) begin : g_we
    assign mem_we_c[gi] = store_gnt & bus.ls_be[gi];
  end

  assign mem_addr_c  = ls_gnt_c ? bus.ls_addr : (if_gnt_c ? bus.if_addr : '0);
  assign mem_wdata_c = store_gnt ? bus.ls_wdata : '0;

  assign if_rvalid_c = ~rst & (rd_owner_reg == IF);
  assign ls_rvalid_c = ~rst & (rd_owner_reg == LS);
  assign stall_if_c  = ~rst & bus.if_req & ~if_gnt_c;
  // A load is in flight in its grant cycle: MEM holds until the data returns next cycle.
  assign stall_mem_c = ~rst & ((bus.ls_req & ~ls_gnt_c) | load_gnt);

  assign bus.if_gnt    = if_gnt_c;
  assign bus.ls_gnt    = ls_gnt_c;
  assign bus.if_rvalid = if_rvalid_c;
  assign bus.ls_rvalid = ls_rvalid_c;
  assign bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = ls_rvalid_c ? bus.mem_rdata : '0;
  assign bus.mem_en    = if_gnt_c | ls_gnt_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.stall_if  = stall_if_c;
  assign bus.stall_mem = stall_mem_c;

`ifdef MEM_ARB_PERF_EN
  logic [1:0]       perf_evt;
  logic [1:0][31:0] perf_val;

  assign perf_evt = {stall_if_c, bus.if_req & bus.ls_req};

  for (gi = 0; gi < 2; gi++) begin : g_perf
    logic [31:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (perf_evt[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end

    assign perf_val[gi] = cnt_reg;
  end

  assign perf_conflict_cnt = perf_val[0];
  assign perf_if_stall_cnt = perf_val[1];
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: directed scenarios followed by random IF/LSU traffic.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int RAND_CYCLES  = 800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt;
  logic [31:0] perf_if_stall_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_conflict_cnt(perf_conflict_cnt),
    .perf_if_stall_cnt(perf_if_stall_cnt)
`endif
  );

  // BRAM behind the arbiter, and the golden word image the model predicts from.
  logic [31:0] bram [256];
  logic [31:0] gold [256];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_we[b]) bram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      bus.mem_rdata <= bram[bus.mem_addr[9:2]];
    end
  end

  typedef struct packed {
    logic        if_gnt;
    logic        ls_gnt;
    logic        mem_en;
    logic        is_store;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall_if;
    logic        stall_mem;
    logic        if_rvalid;
    logic        ls_rvalid;
  } rec_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
  } rd_t;

  rec_t rec_q[$];
  rd_t  if_q[$];
  rd_t  ls_q[$];

  // Reference model state: LSU wins unless IF has been passed over STARVE_LIMIT times in a row.
  int streak = 0;
  bit force_if = 1'b0;
  bit prev_if_rd = 1'b0;
  bit prev_ls_rd = 1'b0;
  int conf_m = 0;
  int stall_m = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                      input bit lr, input bit lw, input logic [3:0] lb,
                      input logic [31:0] la, input logic [31:0] ld,
                      output bit ig, output bit lg);
    rec_t e;
    @(posedge clk);
    #2;
    rst          = r;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.ls_req   = lr;
    bus.ls_we    = lw;
    bus.ls_be    = lb;
    bus.ls_addr  = la;
    bus.ls_wdata = ld;
    e  = '0;
    ig = 1'b0;
    lg = 1'b0;
    if (r) begin
      if (prev_ls_rd && ls_q.size() > 0) void'(ls_q.pop_back());
      if (prev_if_rd && if_q.size() > 0) void'(if_q.pop_back());
      streak     = 0;
      force_if   = 1'b0;
      prev_if_rd = 1'b0;
      prev_ls_rd = 1'b0;
      conf_m     = 0;
      stall_m    = 0;
    end else begin
      if (force_if && ir) ig = 1'b1;
      else if (lr) lg = 1'b1;
      else if (ir) ig = 1'b1;
      e.if_gnt    = ig;
      e.ls_gnt    = lg;
      e.mem_en    = ig | lg;
      e.if_rvalid = prev_if_rd;
      e.ls_rvalid = prev_ls_rd;
      e.stall_if  = ir && !ig;
      e.stall_mem = (lr && !lg) || (lg && !lw);
      if (ig) begin
        e.mem_addr = ia;
        if_q.push_back('{cyc: 32'(cyc + 1), data: gold[ia[9:2]]});
      end
      if (lg) begin
        e.mem_addr = la;
        if (lw) begin
          e.is_store  = 1'b1;
          e.mem_we    = lb;
          e.mem_wdata = ld;
          for (int b = 0; b < 4; b++) begin
            if (lb[b]) gold[la[9:2]][8*b +: 8] = ld[8*b +: 8];
          end
        end else begin
          ls_q.push_back('{cyc: 32'(cyc + 1), data: gold[la[9:2]]});
        end
      end
      if (force_if) begin
        streak   = 0;
        force_if = 1'b0;
      end else if (ig) begin
        streak = 0;
      end else if (lg && ir) begin
        streak++;
        if (STARVE_LIMIT != 0 && streak == STARVE_LIMIT) force_if = 1'b1;
      end
      if (ir && lr) conf_m++;
      if (e.stall_if) stall_m++;
      prev_if_rd = ig;
      prev_ls_rd = lg && !lw;
    end
    rec_q.push_back(e);
  endtask

  // Monitor: compares per-cycle port behaviour and pops read data whenever the DUT signals rvalid.
  initial begin
    rec_t e;
    rd_t  d;
    forever begin
      @(negedge clk);
      if (rec_q.size() > 0) begin
        e = rec_q.pop_front();
        chk("if_gnt", 32'(bus.if_gnt), 32'(e.if_gnt));
        chk("ls_gnt", 32'(bus.ls_gnt), 32'(e.ls_gnt));
        chk("mem_en", 32'(bus.mem_en), 32'(e.mem_en));
        chk("mem_we", 32'(bus.mem_we), 32'(e.mem_we));
        chk("stall_if", 32'(bus.stall_if), 32'(e.stall_if));
        chk("stall_mem", 32'(bus.stall_mem), 32'(e.stall_mem));
        chk("if_rvalid", 32'(bus.if_rvalid), 32'(e.if_rvalid));
        chk("ls_rvalid", 32'(bus.ls_rvalid), 32'(e.ls_rvalid));
        if (e.mem_en) chk("mem_addr", bus.mem_addr, e.mem_addr);
        if (e.is_store) chk("mem_wdata", bus.mem_wdata, e.mem_wdata);
        if (bus.if_gnt || bus.ls_gnt)
          $display("cyc=%0d grant if=%0b ls=%0b addr=%h we=%b", cyc, bus.if_gnt, bus.ls_gnt,
                   bus.mem_addr, bus.mem_we);
      end
      if (bus.if_rvalid) begin
        if (if_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL if_rvalid_unexpected cyc=%0d actual=1 expected=0", cyc);
        end else begin
          d = if_q.pop_front();
          chk("if_rvalid_cycle", 32'(cyc), d.cyc);
          chk("if_rdata", bus.if_rdata, d.data);
        end
      end else begin
        chk("if_rdata_idle", bus.if_rdata, 32'h0);
      end
      if (bus.ls_rvalid) begin
        if (ls_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ls_rvalid_unexpected cyc=%0d actual=1 expected=0", cyc);
        end else begin
          d = ls_q.pop_front();
          chk("ls_rvalid_cycle", 32'(cyc), d.cyc);
          chk("ls_rdata", bus.ls_rdata, d.data);
        end
      end else begin
        chk("ls_rdata_idle", bus.ls_rdata, 32'h0);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ig, lg;
    bit ip, lp, lw, r;
    logic [31:0] ia, la, ld;
    logic [3:0] lb;

    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_be    = '0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      bram[i] = $urandom;
      gold[i] = bram[i];
    end
    bram[64] = 32'h0000_0013;
    gold[64] = 32'h0000_0013;

    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ig, lg);

    // Single fetch of a NOP at 0x100.
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ig, lg);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ig, lg);

    // Fetch and load collide: LSU first, fetch next cycle alongside the load data.
    step(1'b0, 1'b1, 32'h104, 1'b1, 1'b0, 4'h0, 32'h2000, 32'h0, ig, lg);
    step(1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ig, lg);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ig, lg);

    // Both held continuously: four LSU grants, then one forced fetch, repeating.
    for (int k = 0; k < 15; k++)
      step(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'(k * 4), 32'h0, ig, lg);
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ig, lg);

    // Half-word store then load back, then a store with no byte enables.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF, ig, lg);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, ig, lg);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0000, 32'h40, 32'h1234_5678, ig, lg);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, ig, lg);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ig, lg);

    // Reset lands on the cycle a load's data would return.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0, ig, lg);
    step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0, ig, lg);
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ig, lg);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ig, lg);

    ip = 1'b0;
    lp = 1'b0;
    lw = 1'b0;
    lb = '0;
    ia = '0;
    la = '0;
    ld = '0;
    for (int n = 0; n < RAND_CYCLES; n++) begin
      if (!ip && $urandom_range(0, 3) != 0) begin
        ip = 1'b1;
        ia = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!lp && $urandom_range(0, 3) != 0) begin
        lp = 1'b1;
        lw = 1'($urandom_range(0, 1));
        lb = 4'($urandom);
        la = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        ld = $urandom;
      end
      if (ip && $urandom_range(0, 31) == 0) ip = 1'b0;
      if (lp && $urandom_range(0, 31) == 0) lp = 1'b0;
      r = ($urandom_range(0, 199) == 0);
      step(r, ip, ia, lp, lw, lb, la, ld, ig, lg);
      if (ig || r) ip = 1'b0;
      if (lg || r) lp = 1'b0;
    end

    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ig, lg);
    @(negedge clk);
    #1;
    chk("rec_q_drained", 32'(rec_q.size()), 32'h0);
    chk("if_q_drained", 32'(if_q.size()), 32'h0);
    chk("ls_q_drained", 32'(ls_q.size()), 32'h0);
`ifdef MEM_ARB_PERF_EN
    chk("perf_conflict_cnt", perf_conflict_cnt, 32'(conf_m));
    chk("perf_if_stall_cnt", perf_if_stall_cnt, 32'(stall_m));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
